// File: rtl/adder_accumulator_pkg.sv
// adder_accumulator_pkg: shared FSM state encodings and clog2 helper for the accumulator slice
package adder_accumulator_pkg;
  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_DONE  = 1'b1;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/ripple_carry_adder.sv
// ripple_carry_adder: unsigned WIDTH-bit ripple adder, o_result[WIDTH] is the carry-out
//   i_a, i_b  : WIDTH-bit operands
//   o_result  : WIDTH+1-bit sum {carry, sum}
module ripple_carry_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH:0]   o_result
);
  logic [WIDTH-1:0] s;
  logic             c;
  always_comb begin
    s = '0;
    c = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      s[k] = i_a[k] ^ i_b[k] ^ c;
      c    = (i_a[k] & i_b[k]) | (c & (i_a[k] ^ i_b[k]));
    end
    o_result = {c, s};
  end
endmodule

// File: rtl/adder_accumulator.sv
// adder_accumulator: sums TERMS handshaked WIDTH-bit terms into an ACC_WIDTH-bit total with sticky overflow
//   i_clk/i_rst_n            : clock, async active-low reset
//   i_clear                  : sync clear, discards partial or pending total
//   i_term_valid/o_term_ready/i_term : term input handshake
//   o_acc_valid/i_acc_ready/o_acc    : total output handshake
//   o_overflow, o_count      : sticky carry-out flag, terms accepted so far
//   ADDER_ACC_SAT_EN         : when defined, a carry-out saturates acc to all-ones instead of wrapping
module adder_accumulator
  import adder_accumulator_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int TERMS     = 4,
  parameter int ACC_WIDTH = 10,
  localparam int CNT_W    = clog2(TERMS + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clear,
  input  logic                 i_term_valid,
  input  logic [WIDTH-1:0]     i_term,
  output logic                 o_term_ready,
  output logic                 o_acc_valid,
  input  logic                 i_acc_ready,
  output logic [ACC_WIDTH-1:0] o_acc,
  output logic                 o_overflow,
  output logic [CNT_W-1:0]     o_count
);
  logic [0:0]           state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d, acc_add;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic [ACC_WIDTH:0]   sum;
  logic                 term_fire, acc_fire;
  ripple_carry_adder #(.WIDTH(ACC_WIDTH)) u_rca (
    .i_a      (acc_q),
    .i_b      (ACC_WIDTH'(i_term)),
    .o_result (sum)
  );
  assign o_term_ready = (state_q == ST_ACCUM) & ~i_clear;
  assign o_acc_valid  = (state_q == ST_DONE);
  assign o_acc        = acc_q;
  assign o_overflow   = ovf_q;
  assign o_count      = cnt_q;
  assign term_fire    = i_term_valid & o_term_ready;
  assign acc_fire     = o_acc_valid & i_acc_ready;
`ifdef ADDER_ACC_SAT_EN
  // A saturated acc plus any nonzero term carries out again, so it stays all-ones.
  assign acc_add = sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0];
`else
  assign acc_add = sum[ACC_WIDTH-1:0];
`endif
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (i_clear || acc_fire) begin
      state_d = ST_ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else if (term_fire) begin
      acc_d   = acc_add;
      cnt_d   = cnt_q + 1'b1;
      ovf_d   = ovf_q | sum[ACC_WIDTH];
      state_d = (cnt_q == CNT_W'(TERMS - 1)) ? ST_DONE : ST_ACCUM;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule
